// File: rtl/text_banner.sv
// text_banner: renders a run-time-loadable string from the 8x16 font ROM at a
// programmable scale and position, with optional frame-synchronous blinking.
// Two-stage pipeline: stage 1 drives the font ROM address, stage 2 aligns the
// glyph column and pixel-active flag with the ROM's one-cycle read data.
module text_banner #(
  parameter int MAX_CHARS    = 16,
  parameter int SCALE_LOG2   = 3,
  parameter int X0           = 160,
  parameter int Y0           = 128,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        blink_en,
  input  logic        frame_tick,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [6:0]  wr_char,
  input  logic        len_we,
  input  logic [5:0]  len_in,
  output logic [10:0] rom_addr,
  output logic [2:0]  bit_addr,
  output logic        text_on
);

  localparam logic [9:0]  X0_V    = 10'(X0);
  localparam logic [9:0]  Y0_V    = 10'(Y0);
  localparam int          COL_SH  = 3 + SCALE_LOG2;
  localparam logic [10:0] HEIGHT  = 11'(16 << SCALE_LOG2);
  localparam logic [5:0]  MAX_LEN = 6'(MAX_CHARS);
  localparam int          CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Buffer spans the full 5-bit address space so any column index is a legal
  // read; entries at or above MAX_CHARS are never written and never reached
  // because col < len <= MAX_CHARS gates every lookup.
  logic [6:0]       char_buf [0:31];
  logic [5:0]       len;
  logic [CNT_W-1:0] blink_cnt;
  logic             visible;

  logic [9:0]  rel_x;
  logic [9:0]  rel_y;
  logic [9:0]  col;
  logic [2:0]  bit_sel;
  logic [3:0]  row;
  logic [6:0]  glyph;
  logic        in_region;
  logic        hit;

  logic [2:0]  bit_p1;
  logic        vld_p1;

  // Pixel geometry and hit decision; range checks use the untruncated
  // coordinates so pixels left of or above the origin never alias in.
  always_comb begin
    rel_x     = pix_x - X0_V;
    rel_y     = pix_y - Y0_V;
    col       = rel_x >> COL_SH;
    bit_sel   = 3'(rel_x >> SCALE_LOG2);
    row       = 4'(rel_y >> SCALE_LOG2);
    glyph     = char_buf[col[4:0]];
    in_region = (pix_x >= X0_V) && (pix_y >= Y0_V) &&
                (col < {4'b0, len}) && ({1'b0, rel_y} < HEIGHT);
    hit       = in_region && enable && visible;
  end

  // Character buffer and string length; out-of-range writes are dropped and
  // the length saturates at the buffer depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) char_buf[i] <= '0;
      len <= '0;
    end else begin
      if (wr_en && (int'(wr_addr) < MAX_CHARS)) char_buf[wr_addr] <= wr_char;
      if (len_we) len <= (len_in > MAX_LEN) ? MAX_LEN : len_in;
    end
  end

  // Blink timer: counts frame ticks and toggles visibility every
  // BLINK_FRAMES ticks; forced visible while blinking is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1: font ROM address plus the column and hit flag carried forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      bit_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      rom_addr <= hit ? {glyph, row} : 11'd0;
      bit_p1   <= hit ? bit_sel : 3'd0;
      vld_p1   <= hit;
    end
  end

  // Stage 2: column select and pixel-active aligned with ROM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_addr <= '0;
      text_on  <= 1'b0;
    end else begin
      bit_addr <= bit_p1;
      text_on  <= vld_p1;
    end
  end

endmodule
